output_controller: RTL and testbench

Frame-buffer and SDRAM-export block at the back end of the GPU pipeline. It stores one frame of 24-bit RGB pixels from the rasterizer in on-chip block RAM (M9K), indexed by pixel number, and offers random read-back. When the frame is declared complete, it streams every pixel to SDRAM over an Avalon-MM style write master, one 32-bit word per pixel, then raises `finished`.

---
 rtl/output_controller.sv | 137 +++++++++++++
 tb/tb_output_controller.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/output_controller.sv
// output_controller: frame buffer with a host read/write port and an engine that exports the frame to SDRAM.
// Build option OUTPUT_CONTROLLER_RGB_SWAP_EN emits {b,g,r} instead of {r,g,b} in SD_wdata.
module output_controller #(
    parameter int unsigned NUM_PIXELS   = 102400,
    parameter logic [25:0] SD_BASE_ADDR = 26'h0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  write_r,
    input  logic [7:0]  write_g,
    input  logic [7:0]  write_b,
    input  logic        M9_write,
    input  logic        read,
    input  logic [16:0] Pixel_Number,
    output logic [7:0]  read_r,
    output logic [7:0]  read_g,
    output logic [7:0]  read_b,
    input  logic        frame_ready,
    input  logic        waitrequest,
    output logic [25:0] SD_address,
    output logic [31:0] SD_wdata,
    output logic        SD_write,
    output logic        finished
);

    localparam int unsigned AW       = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1;
    localparam logic [16:0] LAST_IDX = 17'(NUM_PIXELS - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_e;

    logic [23:0] mem [NUM_PIXELS];

    state_e      state_q;
    logic [16:0] idx_q;
    logic [23:0] read_pix_q;
    logic [25:0] sd_address_q;
    logic [31:0] sd_wdata_q;
    logic        sd_write_q;
    logic        finished_q;

    logic          host_in_range_s;
    logic [AW-1:0] host_addr_s;
    logic          mem_we_s;

    function automatic logic [31:0] pack_word(input logic [23:0] pix);
`ifdef OUTPUT_CONTROLLER_RGB_SWAP_EN
        return {8'h00, pix[7:0], pix[15:8], pix[23:16]};
`else
        return {8'h00, pix};
`endif
    endfunction

    assign host_in_range_s = (Pixel_Number <= LAST_IDX);
    assign host_addr_s     = Pixel_Number[AW-1:0];
    // Host stores are only accepted while the export engine is parked.
    assign mem_we_s        = M9_write && host_in_range_s && (state_q == IDLE) && reset;

    // Frame memory store port; contents survive reset.
    always_ff @(posedge clk) begin
        if (mem_we_s) begin
            mem[host_addr_s] <= {write_r, write_g, write_b};
        end
    end

    // Host read-back port: old data on a same-cycle write, zero when out of range.
    always_ff @(posedge clk) begin
        if (!reset) begin
            read_pix_q <= 24'h0;
        end else if (read) begin
            read_pix_q <= host_in_range_s ? mem[host_addr_s] : 24'h0;
        end else begin
            read_pix_q <= read_pix_q;
        end
    end

    // Export engine: FETCH loads the pixel straight into the registered bus outputs.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= IDLE;
            idx_q        <= 17'd0;
            sd_address_q <= 26'h0;
            sd_wdata_q   <= 32'h0;
            sd_write_q   <= 1'b0;
            finished_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (frame_ready) begin
                        idx_q   <= 17'd0;
                        state_q <= FETCH;
                    end
                end
                FETCH: begin
                    sd_wdata_q   <= pack_word(mem[idx_q[AW-1:0]]);
                    sd_address_q <= SD_BASE_ADDR + {7'd0, idx_q, 2'b00};
                    sd_write_q   <= 1'b1;
                    state_q      <= WRITE;
                end
                WRITE: begin
                    if (!waitrequest) begin
                        sd_write_q <= 1'b0;
                        if (idx_q == LAST_IDX) begin
                            finished_q <= 1'b1;
                            state_q    <= DONE;
                        end else begin
                            idx_q   <= idx_q + 17'd1;
                            state_q <= FETCH;
                        end
                    end
                end
                DONE: begin
                    if (!frame_ready) begin
                        finished_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign read_r     = read_pix_q[23:16];
    assign read_g     = read_pix_q[15:8];
    assign read_b     = read_pix_q[7:0];
    assign SD_address = sd_address_q;
    assign SD_wdata   = sd_wdata_q;
    assign SD_write   = sd_write_q;
    assign finished   = finished_q;

endmodule

// File: tb/tb_output_controller.sv
// Self-checking bench for output_controller: directed host-port steps, randomized traffic and
// a randomized-stall export, all checked against a simple array model of the frame.
module tb_output_controller;

    localparam int unsigned NPIX = 200;
    localparam logic [25:0] BASE = 26'h3FFFF00;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  write_r, write_g, write_b;
    logic        M9_write, read;
    logic [16:0] Pixel_Number;
    logic [7:0]  read_r, read_g, read_b;
    logic        frame_ready, waitrequest;
    logic [25:0] SD_address;
    logic [31:0] SD_wdata;
    logic        SD_write, finished;

    output_controller #(.NUM_PIXELS(NPIX), .SD_BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .write_r(write_r), .write_g(write_g), .write_b(write_b),
        .M9_write(M9_write), .read(read), .Pixel_Number(Pixel_Number),
        .read_r(read_r), .read_g(read_g), .read_b(read_b),
        .frame_ready(frame_ready), .waitrequest(waitrequest),
        .SD_address(SD_address), .SD_wdata(SD_wdata), .SD_write(SD_write),
        .finished(finished)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    logic [23:0] ref_mem [NPIX];

    int          k, cyc, stall, p, n;
    logic        exp_wr, rd_pend, do_r, do_w;
    logic [23:0] rd_exp, wpix, last_rd;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [23:0] rgb();
        return {read_r, read_g, read_b};
    endfunction

    function automatic logic [31:0] exp_word(input int idx);
        logic [23:0] pix;
        pix = ref_mem[idx];
`ifdef OUTPUT_CONTROLLER_RGB_SWAP_EN
        return {8'h00, pix[7:0], pix[15:8], pix[23:16]};
`else
        return {8'h00, pix};
`endif
    endfunction

    function automatic logic [25:0] exp_addr(input int idx);
        logic [31:0] a;
        a = 32'(BASE) + 32'(idx) * 32'd4;
        return a[25:0];
    endfunction

    task automatic wr(input int pn, input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        Pixel_Number = 17'(pn);
        write_r = r; write_g = g; write_b = b;
        M9_write = 1'b1;
        tick();
        M9_write = 1'b0;
        if (pn < int'(NPIX)) ref_mem[pn] = {r, g, b};
    endtask

    task automatic rd(input int pn, input string tag);
        logic [23:0] e;
        e = (pn < int'(NPIX)) ? ref_mem[pn] : 24'h0;
        Pixel_Number = 17'(pn);
        read = 1'b1;
        tick();
        read = 1'b0;
        check(tag, rgb(), e);
    endtask

    initial begin
        reset = 1'b0; M9_write = 1'b0; read = 1'b0; Pixel_Number = 17'd0;
        write_r = 8'd0; write_g = 8'd0; write_b = 8'd0;
        frame_ready = 1'b0; waitrequest = 1'b0;
        tick(); tick();
        check("rst_rgb", rgb(), 24'h0);
        check("rst_sdwr", SD_write, 1'b0);
        check("rst_addr", SD_address, 26'h0);
        check("rst_data", SD_wdata, 32'h0);
        check("rst_fin", finished, 1'b0);
        reset = 1'b1;
        tick();

        // Directed writes and back-to-back reads.
        wr(1, 8'd100, 8'd100, 8'd100);
        wr(2, 8'd200, 8'd200, 8'd201);
        wr(3, 8'd50, 8'd55, 8'd100);
        read = 1'b1;
        Pixel_Number = 17'd1; tick(); check("rd1", rgb(), {8'd100, 8'd100, 8'd100});
        Pixel_Number = 17'd2; tick(); check("rd2", rgb(), {8'd200, 8'd200, 8'd201});
        Pixel_Number = 17'd3; tick(); check("rd3", rgb(), {8'd50, 8'd55, 8'd100});
        read = 1'b0;
        Pixel_Number = 17'd1; tick(); check("rd_hold", rgb(), {8'd50, 8'd55, 8'd100});

        // Same-cycle write and read to one address returns the old word.
        wr(5, 8'd11, 8'd22, 8'd33);
        Pixel_Number = 17'd5; write_r = 8'd44; write_g = 8'd55; write_b = 8'd66;
        M9_write = 1'b1; read = 1'b1;
        tick();
        check("rdw_old", rgb(), {8'd11, 8'd22, 8'd33});
        ref_mem[5] = {8'd44, 8'd55, 8'd66};
        M9_write = 1'b0;
        tick();
        check("rdw_new", rgb(), {8'd44, 8'd55, 8'd66});
        read = 1'b0;

        // Out-of-range writes ignored, reads return zero.
        wr(int'(NPIX), 8'hDE, 8'hAD, 8'hBE);
        wr(256 + 3, 8'hDE, 8'hAD, 8'hBE);
        rd(int'(NPIX), "oor_rd");
        rd(3, "oor_alias");
        rd(17'h1FFFF, "oor_max");

        // Fill the frame with random colours.
        for (int i = 0; i < int'(NPIX); i++) begin
            wr(i, 8'($urandom), 8'($urandom), 8'($urandom));
        end

        // Random mixed host traffic including out-of-range indices.
        for (n = 0; n < 300; n++) begin
            p = $urandom_range(0, NPIX + 20);
            do_w = 1'($urandom_range(0, 1));
            do_r = (n == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            wpix = 24'($urandom);
            Pixel_Number = 17'(p);
            {write_r, write_g, write_b} = wpix;
            M9_write = do_w; read = do_r;
            if (do_r) last_rd = (p < int'(NPIX)) ? ref_mem[p] : 24'h0;
            tick();
            check(do_r ? "rand_rd" : "rand_hold", rgb(), last_rd);
            if (do_w && p < int'(NPIX)) ref_mem[p] = wpix;
        end
        M9_write = 1'b0; read = 1'b0;

        // Full export with random stalls, a 5-cycle stall on pixel 7, and host traffic.
        frame_ready = 1'b1; waitrequest = 1'b0;
        tick();
        check("exp_lat1", SD_write, 1'b0);
        tick();
        exp_wr = 1'b1; k = 0; cyc = 0; stall = 0; rd_pend = 1'b0;
        while (k < int'(NPIX) && cyc < 4000) begin
            check("exp_wr", SD_write, exp_wr);
            check("exp_fin", finished, 1'b0);
            if (exp_wr) begin
                check("exp_addr", SD_address, exp_addr(k));
                check("exp_data", SD_wdata, exp_word(k));
            end
            if (rd_pend) check("exp_hostrd", rgb(), rd_exp);
            if (exp_wr && k == 7 && stall < 5) begin
                waitrequest = 1'b1;
                stall++;
            end else begin
                waitrequest = ($urandom_range(0, 3) == 0);
            end
            p = $urandom_range(0, NPIX - 1);
            Pixel_Number = 17'(p);
            {write_r, write_g, write_b} = 24'($urandom);
            M9_write = 1'($urandom_range(0, 1));
            read = 1'($urandom_range(0, 1));
            rd_pend = read;
            rd_exp = ref_mem[p];
            tick();
            if (exp_wr && !waitrequest) begin
                k++;
                exp_wr = 1'b0;
            end else if (!exp_wr) begin
                exp_wr = 1'b1;
            end
            cyc++;
        end
        M9_write = 1'b0; read = 1'b0; waitrequest = 1'b0;
        if (rd_pend) check("exp_hostrd", rgb(), rd_exp);
        check("exp_count", k, NPIX);
        check("exp_stall7", stall, 5);
        check("exp_done_fin", finished, 1'b1);
        check("exp_done_wr", SD_write, 1'b0);
        tick();
        check("done_hold", finished, 1'b1);
        frame_ready = 1'b0;
        tick();
        check("done_drop", finished, 1'b0);

        // Host writes accepted again; writes attempted during export left no trace.
        wr(0, 8'h12, 8'h34, 8'h56);
        for (int i = 0; i < int'(NPIX); i++) begin
            rd(i, "post_exp_rd");
        end

        // Reset mid-export at pixel 50, then restart from the base address.
        frame_ready = 1'b1; waitrequest = 1'b0;
        tick(); tick();
        for (int i = 0; i < 50; i++) begin
            tick(); tick();
        end
        check("mid_wr", SD_write, 1'b1);
        check("mid_addr", SD_address, exp_addr(50));
        reset = 1'b0; frame_ready = 1'b0;
        tick();
        check("abort_wr", SD_write, 1'b0);
        check("abort_fin", finished, 1'b0);
        check("abort_addr", SD_address, 26'h0);
        check("abort_rgb", rgb(), 24'h0);
        tick();
        check("abort_wr2", SD_write, 1'b0);
        reset = 1'b1;
        tick();
        check("idle_wr", SD_write, 1'b0);
        frame_ready = 1'b1;
        tick();
        check("restart_lat1", SD_write, 1'b0);
        tick();
        check("restart_wr", SD_write, 1'b1);
        check("restart_addr", SD_address, exp_addr(0));
        check("restart_data", SD_wdata, exp_word(0));
        reset = 1'b0; frame_ready = 1'b0;
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
